// File: rtl/dtcore32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dtcore32_pkg                                                               |
// | Shared types and constants for the dtcore32 data-memory bus controller.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dtcore32_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4,
    S_DRAIN = 3'd5
  } dmem_state_e;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/dmem_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_timeout_ctr                                                           |
// | Saturating bus-cycle counter; expired_o flags the MAX-th counted cycle.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (MAX == 0) begin : g_off
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam int CW = (MAX < 2) ? 1 : $clog2(MAX + 1);
      // expired_o is raised during the last allowed cycle so the FSM leaves on that edge
      localparam logic [CW-1:0] c_LIMIT = CW'(MAX - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_cnt <= '0;
        end else if (clr_i) begin
          r_cnt <= '0;
        end else if (en_i && (r_cnt != c_LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign expired_o = (r_cnt == c_LIMIT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_bus_ctrl                                                              |
// | MEM-stage controller for a single-outstanding req/gnt/rvalid data bus.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_bus_ctrl
  import dtcore32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_valid_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_wstrb_i,
  input  logic [3:0]  mem_rstrb_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        misaligned_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  input  logic        dmem_gnt_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        fault_o
);

  dmem_state_e r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic        w_go, w_latch, w_clr, w_en, w_expired, w_capture;

  assign w_go = mem_valid_i & ~misaligned_i & ~flush_i;
  assign w_en = (r_state == S_REQ) | (r_state == S_WAIT) | (r_state == S_DRAIN);

  dmem_timeout_ctr #(
    .MAX(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (w_clr),
    .en_i     (w_en),
    .expired_o(w_expired)
  );

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_clr        = 1'b0;
    w_capture    = 1'b0;
    dmem_req_o   = 1'b0;
    stall_o      = 1'b0;
    done_o       = 1'b0;
    fault_o      = 1'b0;
    dmem_addr_o  = r_addr;
    dmem_we_o    = r_we;
    dmem_be_o    = r_be;
    dmem_wdata_o = r_wdata;
    case (r_state)
      S_IDLE: begin
        // Zero-cycle issue: bus fields come straight from the stage when a request goes out
        dmem_req_o   = w_go;
        stall_o      = w_go;
        dmem_addr_o  = w_go ? {mem_addr_i[31:2], 2'b00} : 32'h0;
        dmem_we_o    = w_go & mem_we_i;
        dmem_be_o    = w_go ? (mem_we_i ? mem_wstrb_i : mem_rstrb_i) : 4'h0;
        dmem_wdata_o = w_go ? mem_wdata_i : 32'h0;
        if (w_go) begin
          w_latch = 1'b1;
          w_clr   = 1'b1;
          w_next  = dmem_gnt_i ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i)     w_next = flush_i ? S_DRAIN : S_WAIT;
        else if (flush_i)   w_next = S_IDLE;
        else if (w_expired) w_next = S_ERR;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          w_capture = ~r_we;
          w_next    = S_DONE;
        end else if (flush_i) begin
          w_next = S_DRAIN;
        end else if (w_expired) begin
          w_next = S_ERR;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        fault_o = 1'b1;
        w_next  = S_IDLE;
      end
      S_DRAIN: begin
        stall_o = mem_valid_i;
        if (dmem_rvalid_i || w_expired) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr  <= {mem_addr_i[31:2], 2'b00};
        r_we    <= mem_we_i;
        r_be    <= mem_we_i ? mem_wstrb_i : mem_rstrb_i;
        r_wdata <= mem_wdata_i;
      end
      if (w_capture) r_rdata <= dmem_rdata_i;
    end
  end

  assign mem_rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dmem_bus_ctrl                                                           |
// | Scoreboard bench: directed accesses, pulses checked by a separate monitor. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_bus_ctrl;

  logic        clk, rst_ni;
  logic        mem_valid, mem_we, misaligned, flush;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb, mem_rstrb;
  logic        req, gnt, we, rvalid;
  logic [31:0] addr, wdata, rdata, mem_rdata;
  logic [3:0]  be;
  logic        stall, done, fault;

  typedef struct {
    logic        is_fault;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];

  int n_chk = 0;
  int n_bad = 0;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .mem_valid_i  (mem_valid),
    .mem_we_i     (mem_we),
    .mem_addr_i   (mem_addr),
    .mem_wstrb_i  (mem_wstrb),
    .mem_rstrb_i  (mem_rstrb),
    .mem_wdata_i  (mem_wdata),
    .misaligned_i (misaligned),
    .flush_i      (flush),
    .dmem_req_o   (req),
    .dmem_gnt_i   (gnt),
    .dmem_addr_o  (addr),
    .dmem_we_o    (we),
    .dmem_be_o    (be),
    .dmem_wdata_o (wdata),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i (rdata),
    .mem_rdata_o  (mem_rdata),
    .stall_o      (stall),
    .done_o       (done),
    .fault_o      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    if (rst_ni && (done || fault)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'h0, fault, done}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {30'h0, fault, done}, e.is_fault ? 32'h2 : 32'h1);
        chk("pulse_rdata", mem_rdata, e.rdata);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; mem_valid = 0; mem_we = 0; misaligned = 0; flush = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; mem_rstrb = 0;
    gnt = 0; rvalid = 0; rdata = 0;
    smp();
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pulses", {done, fault}, 0);
    chk("rst_bus", {addr[31:0] | wdata, 4'(be), 1'(we)}, 0);
    chk("rst_rdata", mem_rdata, 0);
    step(); rst_ni = 1'b1;

    // Load, immediate grant
    step(); mem_valid = 1; mem_we = 0; mem_addr = 32'h1000_0006; mem_rstrb = 4'b1100; gnt = 1;
    q.push_back('{1'b0, 32'hAABB_CCDD});
    smp();
    chk("ld_req", req, 1); chk("ld_addr", addr, 32'h1000_0004);
    chk("ld_be", be, 4'b1100); chk("ld_we", we, 0); chk("ld_stall0", stall, 1);
    step(); gnt = 0; rvalid = 1; rdata = 32'hAABB_CCDD;
    smp(); chk("ld_stall1", stall, 1); chk("ld_req1", req, 0);
    step(); rvalid = 0; rdata = 0;
    smp(); chk("ld_done_stall", stall, 0); chk("ld_done", done, 1);
    step(); mem_valid = 0;
    smp(); chk("ld_rdata_hold", mem_rdata, 32'hAABB_CCDD);

    // Store, grant withheld for three cycles
    step(); mem_valid = 1; mem_we = 1; mem_addr = 32'h2000_0012; mem_wstrb = 4'b0011;
    mem_wdata = 32'hCAFE_F00D; gnt = 0;
    q.push_back('{1'b0, 32'hAABB_CCDD});
    smp(); chk("st_req0", req, 1); chk("st_we0", we, 1);
    step(); mem_addr = 32'hFFFF_FFFF; mem_wdata = 32'h0; mem_wstrb = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) gnt = 1;
      smp();
      chk("st_req_hold", req, 1); chk("st_addr_hold", addr, 32'h2000_0010);
      chk("st_wdata_hold", wdata, 32'hCAFE_F00D); chk("st_be_hold", be, 4'b0011);
      chk("st_we_hold", we, 1); chk("st_stall_hold", stall, 1);
      step();
    end
    gnt = 0; rvalid = 1; rdata = 32'h5555_5555;
    smp(); chk("st_wait_req", req, 0); chk("st_wait_stall", stall, 1);
    step(); rvalid = 0;
    smp(); chk("st_done", done, 1);
    step(); mem_valid = 0; mem_we = 0;

    // Misaligned: no request, stall or pulse
    misaligned = 1; mem_valid = 1;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("mis_req", req, 0); chk("mis_stall", stall, 0);
      step();
    end
    misaligned = 0; mem_valid = 0;

    // Flush before grant
    step(); mem_valid = 1; mem_addr = 32'h3000_0000; mem_rstrb = 4'b1111; gnt = 0;
    smp(); chk("fb_req0", req, 1);
    step(); flush = 1;
    smp(); chk("fb_req1", req, 1); chk("fb_stall1", stall, 1);
    step(); flush = 0; mem_valid = 0;
    smp(); chk("fb_req_drop", req, 0); chk("fb_stall_drop", stall, 0);

    // Flush after grant: drain without updating read data
    step(); mem_valid = 1; mem_addr = 32'h4000_0000; gnt = 1;
    smp(); chk("fa_req", req, 1);
    step(); gnt = 0; flush = 1;
    smp(); chk("fa_wait_stall", stall, 1);
    step(); flush = 0; mem_valid = 0;
    smp(); chk("fa_drain_stall", stall, 0);
    step(); rvalid = 1; rdata = 32'h1234_5678;
    smp(); chk("fa_drain_req", req, 0);
    step(); rvalid = 0; rdata = 0;
    smp(); chk("fa_rdata_kept", mem_rdata, 32'hAABB_CCDD);

    // Timeout in WAIT with TIMEOUT_CYCLES = 4
    step(); mem_valid = 1; mem_addr = 32'h5000_0000; gnt = 1;
    q.push_back('{1'b1, 32'hAABB_CCDD});
    smp();
    step(); gnt = 0;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("to_stall", stall, 1); chk("to_nofault", fault, 0);
      step();
    end
    mem_valid = 0;
    smp(); chk("to_fault", fault, 1); chk("to_release", stall, 0);
    step(); rvalid = 1; rdata = 32'hDEAD_BEEF;
    smp(); chk("to_late_req", req, 0);
    step(); rvalid = 0;
    smp(); chk("to_late_rdata", mem_rdata, 32'hAABB_CCDD);

    // Reset asserted mid-WAIT
    step(); mem_valid = 1; mem_we = 1; mem_addr = 32'h6000_0008; mem_wstrb = 4'b1111;
    mem_wdata = 32'h0102_0304; gnt = 1;
    smp();
    step(); gnt = 0;
    smp(); chk("rw_stall", stall, 1); chk("rw_we", we, 1);
    #2; rst_ni = 1'b0; mem_valid = 0; mem_we = 0; mem_wdata = 0; mem_wstrb = 0; mem_addr = 0;
    #1;
    chk("ra_stall", stall, 0); chk("ra_req", req, 0); chk("ra_we", we, 0);
    chk("ra_addr", addr, 0); chk("ra_be", be, 0); chk("ra_wdata", wdata, 0);
    chk("ra_pulses", {done, fault}, 0); chk("ra_rdata", mem_rdata, 0);
    step(); step(); rst_ni = 1'b1;
    step();
    smp(); chk("post_rst_req", req, 0); chk("post_rst_stall", stall, 0);
    step();

    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Memory-stage data-bus controller: takes the MEM-stage load/store request, runs it over a single-outstanding req/gnt/rvalid data-memory bus, stalls the pipeline until the response returns, and registers read data for the load-extraction logic. Sits between the MEM-stage pipeline register and the data memory. Its `mem_rdata_o` feeds the load unit's `mem_rdata_i`. It takes `mem_rstrb` and `misaligned_load` from the load unit.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed in REQ+WAIT before an access fault; 0 disables the timeout.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `mem_valid_i`  in  1  MEM stage holds a load or store.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address; the bus is driven with `{addr[31:2],2'b00}`.
- `mem_wstrb_i`  in  4  store byte enables, pre-shifted.
- `mem_rstrb_i`  in  4  load byte enables from the load unit.
- `mem_wdata_i`  in  32  store data, pre-shifted.
- `misaligned_i`  in  1  misaligned access; no bus request is issued.
- `flush_i`  in  1  pipeline flush of the MEM stage.
- `dmem_req_o`  out  1  bus request.
- `dmem_gnt_i`  in  1  bus grant.
- `dmem_addr_o`  out  32  word address.
- `dmem_we_o`  out  1  write enable.
- `dmem_be_o`  out  4  byte enables: `wstrb` when writing, `rstrb` when reading.
- `dmem_wdata_o`  out  32  write data.
- `dmem_rvalid_i`  in  1  response valid; also the store acknowledge.
- `dmem_rdata_i`  in  32  response data.
- `mem_rdata_o`  out  32  registered read word to the load unit.
- `stall_o`  out  1  holds the MEM stage and everything upstream.
- `done_o`  out  1  one-cycle pulse: access complete.
- `fault_o`  out  1  one-cycle pulse: access timed out.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR, DRAIN. Reset state is IDLE.
- Issue condition is `go = mem_valid_i & ~misaligned_i & ~flush_i`.
- **IDLE**
  - `dmem_req_o = go`, combinational, with bus fields taken directly from the inputs; `stall_o = go`.
  - On `go & gnt`, go to WAIT. On `go & ~gnt`, go to REQ.
  - In both cases latch addr, we, be and wdata into registers.
- **REQ**
  - `dmem_req_o = 1`, driven from the latched fields; `stall_o = 1`.
  - On `gnt`, go to WAIT.
  - On `flush_i` with `~gnt`, withdraw the request and go to IDLE. The bus permits withdrawal before grant.
  - `flush_i` together with `gnt` goes to DRAIN.
- **WAIT**
  - `stall_o = 1`.
  - On `rvalid`, capture `dmem_rdata_i` into `mem_rdata_o` (loads only; stores leave it unchanged) and go to DONE.
  - On `flush_i` without `rvalid`, go to DRAIN.
- **DONE**
  - `stall_o = 0` and `done_o = 1`; the stage advances at the end of this cycle.
  - Always go to IDLE. A new request cannot issue in this cycle.
- **ERR**
  - Entered from REQ or WAIT when the cycle counter reaches `TIMEOUT_CYCLES`.
  - `stall_o = 0` and `fault_o = 1`; go to IDLE.
  - From REQ, the request is dropped. From WAIT, a late `rvalid` is ignored.
- **DRAIN**
  - A granted access was flushed; wait for its `rvalid` without updating `mem_rdata_o`.
  - `stall_o = mem_valid_i`; go to IDLE on `rvalid`.
  - The timeout also applies: on expiry, go to IDLE with no fault.
- The cycle counter clears on entry to REQ or WAIT from IDLE, increments each cycle in REQ/WAIT/DRAIN, and saturates.
- `rvalid` in IDLE, REQ, DONE or ERR is ignored.
- Misaligned or flushed requests in IDLE produce no request, no stall and no pulse.

## Timing
- Reset values: state IDLE; `dmem_req_o`, `stall_o`, `done_o`, `fault_o`, `dmem_we_o` = 0; `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `mem_rdata_o` = 0.
- Asynchronous assert, synchronous release.
- Best case, with `gnt` in the IDLE cycle and `rvalid` in the next cycle:
  - Stall lasts 2 cycles and `done_o` rises in cycle 3.
  - `mem_rdata_o` is valid from the DONE cycle until the next load's `rvalid`.
- `rvalid` arrives no earlier than the cycle after `gnt`.
- One outstanding access at a time.
- Bus fields are stable from the REQ cycle through `gnt`.
- Reset mid-access abandons the access. The bus side is reset by the same `rst_ni`.

## Structure
- Shared package `dtcore32_pkg`: `dmem_state_e` enum (6 states) and a `DMEM_TIMEOUT_DEFAULT` constant.
- Sub-module `dmem_timeout_ctr`: saturating counter with clear/enable inputs and an `expired` output; tied inactive when `TIMEOUT_CYCLES == 0`.
- FSM, field registers and output muxing live in the top module.

## Test plan
- **Load, immediate grant:** load at `0x1000_0006`, `rstrb = 4'b1100`, `gnt` at cycle 0, `rvalid` at cycle 1 with `0xAABBCCDD`.
  - Required: `dmem_addr_o = 0x1000_0004`, `be = 4'b1100`; stall for cycles 0–1; `done_o` at cycle 2; `mem_rdata_o = 0xAABBCCDD`.
- **Store, delayed grant:** `gnt` withheld for 3 cycles.
  - Required: `req` held with stable addr/wdata/be; `we = 1`; `done_o` after `rvalid`; `mem_rdata_o` unchanged.
- **Misaligned:** `misaligned_i = 1`.
  - Required: `dmem_req_o` stays 0, `stall_o` stays 0, no `done_o`.
- **Flush before grant:** flush in REQ.
  - Required: `req` drops the next cycle; IDLE.
- **Flush after grant:** flush in WAIT.
  - Required: DRAIN; `rvalid` with `0x12345678` does not change `mem_rdata_o`; no `done_o`.
- **Timeout:** `TIMEOUT_CYCLES = 4`, no `rvalid`.
  - Required: `fault_o` pulse and stall release exactly 4 cycles after WAIT entry.
  - Also: assert `rst_ni` low mid-WAIT; all outputs go to reset values immediately.
